// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt controller: prioritises one event per instruction, reports it to CP0
// and runs a flush FSM that drives the redirect PC. Define EXC_OV_TRAP_EN to enable overflow/trap codes.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_excepttype_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_is_in_delayslot_i,
    input  logic        mem_inst_valid_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam logic [4:0]  CP0_STATUS = 5'd12;
    localparam logic [4:0]  CP0_CAUSE  = 5'd13;
    localparam logic [4:0]  CP0_EPC    = 5'd14;
    localparam logic [31:0] CODE_NONE  = 32'h0;
    localparam logic [31:0] CODE_INT   = 32'h1;
    localparam logic [31:0] CODE_SYS   = 32'h8;
    localparam logic [31:0] CODE_INV   = 32'ha;
    localparam logic [31:0] CODE_OV    = 32'hc;
    localparam logic [31:0] CODE_TRAP  = 32'hd;
    localparam logic [31:0] CODE_ERET  = 32'he;
    localparam logic [3:0]  CNT_INIT   = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic [31:0] r_new_pc, w_new_pc_next;

    logic [31:0] w_status_eff, w_cause_eff, w_epc_eff;
    logic        w_irq, w_detect;
    logic [31:0] w_code;
    logic        w_unused;

    always_comb begin
        w_status_eff = cp0_status_i;
        w_cause_eff  = cp0_cause_i;
        w_epc_eff    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            if (wb_cp0_waddr_i == CP0_STATUS) w_status_eff = wb_cp0_data_i;
            if (wb_cp0_waddr_i == CP0_EPC)    w_epc_eff    = wb_cp0_data_i;
            // mtc0 to cause only reaches the software-writable fields
            if (wb_cp0_waddr_i == CP0_CAUSE) begin
                w_cause_eff[9:8] = wb_cp0_data_i[9:8];
                w_cause_eff[23]  = wb_cp0_data_i[23];
                w_cause_eff[22]  = wb_cp0_data_i[22];
            end
        end
    end

    assign w_irq = ((w_cause_eff[15:8] & w_status_eff[15:8]) != 8'h0) &&
                   !w_status_eff[1] && w_status_eff[0];

    assign w_detect = (r_state == StIdle) && mem_inst_valid_i && !rst;

    always_comb begin
        w_code = CODE_NONE;
        if (w_irq)                    w_code = CODE_INT;
        else if (mem_excepttype_i[8]) w_code = CODE_SYS;
        else if (mem_excepttype_i[9]) w_code = CODE_INV;
`ifdef EXC_OV_TRAP_EN
        else if (mem_excepttype_i[11]) w_code = CODE_OV;
        else if (mem_excepttype_i[10]) w_code = CODE_TRAP;
`endif
        else if (mem_excepttype_i[12]) w_code = CODE_ERET;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= 4'd0;
            r_new_pc <= 32'h0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_new_pc <= w_new_pc_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_new_pc_next = r_new_pc;
        unique case (r_state)
            StIdle: begin
                if (w_detect && (w_code != CODE_NONE)) begin
                    w_state_next  = StFlush;
                    w_cnt_next    = CNT_INIT;
                    w_new_pc_next = (w_code == CODE_ERET) ? w_epc_eff : EXC_VECTOR;
                end
            end
            StFlush: begin
                if (r_cnt != 4'd0) w_cnt_next   = r_cnt - 4'd1;
                else               w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        excepttype_o        = w_detect ? w_code : CODE_NONE;
        current_inst_addr_o = mem_pc_i;
        is_in_delayslot_o   = mem_is_in_delayslot_i;
        flush_o             = (r_state == StFlush);
        new_pc_o            = r_new_pc;
    end

    assign w_unused = ^{mem_excepttype_i, w_status_eff, w_cause_eff, CODE_OV, CODE_TRAP};

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: two instances (FLUSH_CYCLES 1 and 3) driven in lockstep and checked against
// a behavioural model of event priority, forwarding and flush timing.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_excepttype_i, mem_pc_i;
    logic        mem_is_in_delayslot_i, mem_inst_valid_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;

    logic [31:0] o_exc [2];
    logic [31:0] o_addr [2];
    logic        o_ds [2];
    logic        o_flush [2];
    logic [31:0] o_npc [2];

    int          n_checks = 0;
    int          n_fail = 0;
    int          m_rem [2] = '{0, 0};
    logic [31:0] m_pc [2] = '{32'h0, 32'h0};
    int          fc [2] = '{1, 3};

    always #5 clk = ~clk;

    exc_ctrl u_dut1 (
        .clk(clk), .rst(rst), .mem_excepttype_i(mem_excepttype_i), .mem_pc_i(mem_pc_i),
        .mem_is_in_delayslot_i(mem_is_in_delayslot_i), .mem_inst_valid_i(mem_inst_valid_i),
        .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
        .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
        .excepttype_o(o_exc[0]), .current_inst_addr_o(o_addr[0]), .is_in_delayslot_o(o_ds[0]),
        .flush_o(o_flush[0]), .new_pc_o(o_npc[0])
    );

    exc_ctrl #(.FLUSH_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .mem_excepttype_i(mem_excepttype_i), .mem_pc_i(mem_pc_i),
        .mem_is_in_delayslot_i(mem_is_in_delayslot_i), .mem_inst_valid_i(mem_inst_valid_i),
        .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
        .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
        .excepttype_o(o_exc[1]), .current_inst_addr_o(o_addr[1]), .is_in_delayslot_o(o_ds[1]),
        .flush_o(o_flush[1]), .new_pc_o(o_npc[1])
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] cur);
        return (wb_cp0_we_i && wb_cp0_waddr_i == addr) ? wb_cp0_data_i : cur;
    endfunction

    // Event code the spec's priority rules give for the current inputs, ignoring FSM state.
    function automatic logic [31:0] ref_code();
        logic [31:0] st, ca, mask;
        logic [31:0] f;
        st   = fwd(5'd12, cp0_status_i);
        mask = 32'h00C0_0300;
        ca   = (cp0_cause_i & ~mask) | (fwd(5'd13, cp0_cause_i) & mask);
        f    = mem_excepttype_i;
        if (((ca[15:8] & st[15:8]) != 0) && st[1] == 1'b0 && st[0] == 1'b1) return 32'h1;
        if (f[8]) return 32'h8;
        if (f[9]) return 32'ha;
`ifdef EXC_OV_TRAP_EN
        if (f[11]) return 32'hc;
        if (f[10]) return 32'hd;
`endif
        if (f[12]) return 32'he;
        return 32'h0;
    endfunction

    task automatic step();
        logic [31:0] code, ec [2];
        #1;
        code = ref_code();
        for (int k = 0; k < 2; k++) begin
            ec[k] = (m_rem[k] == 0 && mem_inst_valid_i && !rst) ? code : 32'h0;
            chk("excepttype", k, o_exc[k], ec[k]);
            chk("inst_addr", k, o_addr[k], mem_pc_i);
            chk("delayslot", k, {31'h0, o_ds[k]}, {31'h0, mem_is_in_delayslot_i});
            chk("flush", k, {31'h0, o_flush[k]}, {31'h0, m_rem[k] > 0});
            chk("new_pc", k, o_npc[k], m_pc[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_rem[k] = 0;
                m_pc[k]  = 32'h0;
            end else if (m_rem[k] > 0) begin
                m_rem[k]--;
            end else if (ec[k] != 0) begin
                m_rem[k] = fc[k];
                m_pc[k]  = (ec[k] == 32'he) ? fwd(5'd14, cp0_epc_i) : 32'h20;
            end
        end
        #1;
    endtask

    task automatic quiet();
        rst = 1'b0; mem_excepttype_i = 0; mem_pc_i = 32'h8000_0000;
        mem_is_in_delayslot_i = 0; mem_inst_valid_i = 0;
        cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
        wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_data_i = 0;
    endtask

    task automatic drain();
        quiet();
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        quiet();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        step();

        // Interrupt: IE set, IP2 pending and unmasked
        cp0_status_i = 32'h1000_FF01; cp0_cause_i = 32'h0000_0400;
        mem_inst_valid_i = 1; mem_pc_i = 32'h8000_0100;
        step();
        drain();

        // Syscall in delay slot
        mem_excepttype_i = 32'h100; mem_is_in_delayslot_i = 1; mem_pc_i = 32'h104;
        mem_inst_valid_i = 1;
        step();
        drain();

        // Eret with same-cycle mtc0 EPC
        mem_excepttype_i = 32'h1000; cp0_epc_i = 32'h100; mem_inst_valid_i = 1;
        wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h200;
        step();
        wb_cp0_we_i = 0; cp0_epc_i = 32'h300;
        step();
        drain();

        // Syscall then invalid held during flush
        mem_excepttype_i = 32'h100; mem_inst_valid_i = 1;
        step();
        mem_excepttype_i = 32'h200;
        for (int i = 0; i < 4; i++) step();
        drain();

        // Pending IRQ masked by forwarded status write
        cp0_status_i = 32'h1000_FF01; cp0_cause_i = 32'h0000_0400; mem_inst_valid_i = 1;
        wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h0000_FF00;
        step();
        step();
        // Bubble with IRQ pending, then a valid instruction takes it
        wb_cp0_we_i = 0; mem_inst_valid_i = 0;
        step();
        mem_inst_valid_i = 1;
        step();
        drain();

        // Overflow and trap flags, plus multi-flag priority
        mem_excepttype_i = 32'h800; mem_inst_valid_i = 1;
        step();
        drain();
        mem_excepttype_i = 32'h400; mem_inst_valid_i = 1;
        step();
        drain();
        mem_excepttype_i = 32'h1E00; mem_inst_valid_i = 1;
        step();
        drain();

        // Reset one cycle into a flush aborts it
        mem_excepttype_i = 32'h100; mem_inst_valid_i = 1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        drain();

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            mem_inst_valid_i = ($urandom_range(0, 3) != 0);
            mem_excepttype_i = 0;
            for (int b = 8; b <= 12; b++)
                if ($urandom_range(0, 5) == 0) mem_excepttype_i[b] = 1'b1;
            mem_pc_i = $urandom;
            mem_is_in_delayslot_i = 1'($urandom_range(0, 1));
            cp0_status_i = ($urandom_range(0, 1) != 0) ? 32'h1000_FF01 : $urandom;
            cp0_cause_i = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
            cp0_epc_i = $urandom;
            wb_cp0_we_i = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: wb_cp0_waddr_i = 5'd12;
                1: wb_cp0_waddr_i = 5'd13;
                2: wb_cp0_waddr_i = 5'd14;
                default: wb_cp0_waddr_i = 5'($urandom);
            endcase
            wb_cp0_data_i = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
